// File: rtl/wb_commit_checker.sv
// Writeback commit checker: shadows register-file writes during a run window,
// then compares the shadow against a loaded expected table and reports results.
module wb_commit_checker #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 3,
  parameter int RUN_CYCLES = 48,
  parameter int ZERO_R0    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt,
  input  logic                wb_en,
  input  logic [REG_AW-1:0]   wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                exp_we,
  input  logic [REG_AW-1:0]   exp_idx,
  input  logic [DATA_W-1:0]   exp_val,
  input  logic                exp_chk,
  input  logic [REG_AW-1:0]   rd_idx,
  output logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [REG_AW:0]     mismatch_cnt,
  output logic [REG_AW-1:0]   first_bad,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    write_cnt
);
  localparam int NREG = 2 ** REG_AW;
  localparam logic [CNT_W-1:0]  LAST_CYC = CNT_W'(RUN_CYCLES - 1);
  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREG - 1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   shadow  [NREG];
  logic [DATA_W-1:0]   exp_tbl [NREG];
  logic [NREG-1:0]     chk_tbl;
  logic [REG_AW-1:0]   chk_idx;
  logic                start_run, wb_store, tbl_open, bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = RUN;
        start_run = 1'b1;
      end
      RUN:   if (halt || cycle_cnt == LAST_CYC) state_nxt = CHECK;
      CHECK: if (chk_idx == LAST_IDX) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // r0 writes still count as accepted writebacks even when dropped from the shadow
  assign wb_store = (state == RUN) && wb_en && !((ZERO_R0 != 0) && (wb_reg == '0));
  assign tbl_open = (state == IDLE) || (state == DONE);
  assign bad      = (state == CHECK) && chk_tbl[chk_idx] && (shadow[chk_idx] != exp_tbl[chk_idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cycle_cnt    <= '0;
      write_cnt    <= '0;
      mismatch_cnt <= '0;
      first_bad    <= '0;
      chk_idx      <= '0;
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else begin
      state <= state_nxt;
      if (start_run) begin
        cycle_cnt    <= '0;
        write_cnt    <= '0;
        mismatch_cnt <= '0;
        first_bad    <= '0;
        chk_idx      <= '0;
        for (int i = 0; i < NREG; i++) shadow[i] <= '0;
      end else begin
        if (state == RUN) begin
          cycle_cnt <= sat_inc(cycle_cnt);
          if (wb_en) write_cnt <= sat_inc(write_cnt);
          if (wb_store) shadow[wb_reg] <= wb_data;
        end
        if (state == CHECK) begin
          chk_idx <= chk_idx + REG_AW'(1);
          if (bad) begin
            mismatch_cnt <= mismatch_cnt + (REG_AW + 1)'(1);
            if (mismatch_cnt == '0) first_bad <= chk_idx;
          end
        end
      end
    end
  end

  // Expected table survives start; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_tbl <= '0;
      for (int i = 0; i < NREG; i++) exp_tbl[i] <= '0;
    end else if (exp_we && tbl_open) begin
      exp_tbl[exp_idx] <= exp_val;
      chk_tbl[exp_idx] <= exp_chk;
    end
  end

  assign rd_data = shadow[rd_idx];
  assign busy    = (state == RUN) || (state == CHECK);
  assign done    = (state == DONE);
  assign pass    = done && (mismatch_cnt == '0);
  assign fail    = done && (mismatch_cnt != '0);

endmodule

// File: tb/tb_wb_commit_checker.sv
// Scoreboard bench for wb_commit_checker: stimulus pushes predicted results,
// a monitor pops and compares them when done rises.
module tb_wb_commit_checker;
  localparam int R    = 48;
  localparam int NREG = 8;

  logic        clk = 0, reset = 1, start = 0, halt = 0, wb_en = 0;
  logic        exp_we = 0, exp_chk = 0;
  logic [2:0]  wb_reg = 0, exp_idx = 0, rd_idx = 0;
  logic [15:0] wb_data = 0, exp_val = 0;
  logic [15:0] rd_data;
  logic        busy, done, pass, fail;
  logic [3:0]  mismatch_cnt;
  logic [2:0]  first_bad;
  logic [15:0] cycle_cnt, write_cnt;

  wb_commit_checker #(.DATA_W(16), .REG_AW(3), .RUN_CYCLES(R), .ZERO_R0(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_val(exp_val), .exp_chk(exp_chk),
    .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .mismatch_cnt(mismatch_cnt), .first_bad(first_bad), .cycle_cnt(cycle_cnt), .write_cnt(write_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  typedef struct {
    int dc; bit p; bit f; int mm; int fb; int cc; int wc;
  } exp_t;
  exp_t sbq[$];

  // Reference state: expected table and predicted shadow contents
  logic [15:0] m_val [NREG];
  bit          m_chk [NREG];
  logic [15:0] m_sh  [NREG];

  // Per-run writeback schedule, indexed by RUN cycle number (1-based)
  bit          wen  [64];
  logic [2:0]  wreg [64];
  logic [15:0] wdat [64];

  logic done_q = 0;
  exp_t e_mon;
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sbq.size() == 0) chk("unexpected_done", 32'(1), 32'(0));
      else begin
        e_mon = sbq.pop_front();
        chk("done_cycle", cyc, e_mon.dc);
        chk("pass", 32'(pass), 32'(e_mon.p));
        chk("fail", 32'(fail), 32'(e_mon.f));
        chk("mismatch_cnt", 32'(mismatch_cnt), e_mon.mm);
        chk("first_bad", 32'(first_bad), e_mon.fb);
        chk("cycle_cnt", 32'(cycle_cnt), e_mon.cc);
        chk("write_cnt", 32'(write_cnt), e_mon.wc);
      end
    end
    done_q <= done;
  end

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_val[i] = '0; m_chk[i] = 0;
    end
  endtask

  task automatic clear_w();
    for (int j = 0; j < 64; j++) begin
      wen[j] = 0; wreg[j] = '0; wdat[j] = '0;
    end
  endtask

  task automatic add_w(input int j, input int rg, input int d);
    wen[j] = 1; wreg[j] = 3'(rg); wdat[j] = 16'(d);
  endtask

  task automatic load(input int idx, input int val, input bit c);
    exp_we = 1; exp_idx = 3'(idx); exp_val = 16'(val); exp_chk = c;
    @(posedge clk); #1;
    exp_we = 0;
    m_val[idx] = 16'(val); m_chk[idx] = c;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
    chk({tag, "_mm"}, 32'(mismatch_cnt), 0);
    chk({tag, "_fb"}, 32'(first_bad), 0);
    chk({tag, "_cc"}, 32'(cycle_cnt), 0);
    chk({tag, "_wc"}, 32'(write_cnt), 0);
    for (int i = 0; i < NREG; i++) begin
      rd_idx = 3'(i); #1;
      chk({tag, "_rd"}, 32'(rd_data), 0);
    end
  endtask

  task automatic run(input int halt_at, input bit we_in_run, input int we_idx,
                     input bit start_in_chk, input bit we_with_start,
                     input int ws_idx, input int ws_val, input bit ws_chk);
    int last, wc, mm, fb, k, t;
    exp_t e;
    if (we_with_start) begin
      m_val[ws_idx] = 16'(ws_val); m_chk[ws_idx] = ws_chk;
    end
    last = (halt_at > 0 && halt_at < R) ? halt_at : R;
    for (int i = 0; i < NREG; i++) m_sh[i] = '0;
    wc = 0;
    for (int j = 1; j <= last; j++)
      if (wen[j]) begin
        wc++;
        if (wreg[j] != 0) m_sh[wreg[j]] = wdat[j];
      end
    mm = 0; fb = 0;
    for (int i = 0; i < NREG; i++)
      if (m_chk[i] && m_sh[i] != m_val[i]) begin
        if (mm == 0) fb = i;
        mm++;
      end
    k = cyc + 1;
    e.dc = k + last + NREG; e.p = (mm == 0); e.f = (mm != 0);
    e.mm = mm; e.fb = fb; e.cc = last; e.wc = wc;
    sbq.push_back(e);

    start = 1;
    if (we_with_start) begin
      exp_we = 1; exp_idx = 3'(ws_idx); exp_val = 16'(ws_val); exp_chk = ws_chk;
    end
    @(posedge clk); #1;
    start = 0; exp_we = 0;
    chk("busy_after_start", 32'(busy), 1);
    for (int j = 1; j <= last + 4; j++) begin
      wb_en = wen[j]; wb_reg = wreg[j]; wb_data = wdat[j];
      halt = (j == halt_at);
      exp_we = we_in_run && (j == 2);
      exp_idx = 3'(we_idx); exp_val = ~m_val[we_idx]; exp_chk = 1;
      start = start_in_chk && (j == last + 3);
      @(posedge clk); #1;
    end
    wb_en = 0; halt = 0; exp_we = 0; start = 0;
    t = 0;
    while (!done && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (!done) begin
      chk("done_timeout", 32'(0), 32'(1));
      sbq.delete();
    end else begin
      @(negedge clk); #1;
      for (int i = 0; i < NREG; i++) begin
        rd_idx = 3'(i); #1;
        chk("rd_data", 32'(rd_data), 32'(m_sh[i]));
      end
    end
  endtask

  task automatic golden_table();
    load(1, 10, 1); load(2, 20, 1); load(3, 30, 1); load(4, 10, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ha, last, r0;
    model_reset();
    clear_w();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 0;
    @(posedge clk); #1;

    // Golden run
    golden_table();
    clear_w();
    add_w(2, 1, 10); add_w(5, 2, 20); add_w(9, 3, 30); add_w(12, 4, 10);
    run(0, 0, 0, 0, 0, 0, 0, 0);

    // Mismatch, with a dropped table write in RUN and a start during CHECK
    clear_w();
    add_w(2, 1, 10); add_w(5, 2, 20); add_w(9, 3, 31); add_w(12, 4, 9);
    run(0, 1, 1, 1, 0, 0, 0, 0);

    // r0 hard-wired zero and last writer wins
    load(0, 0, 1); load(1, 0, 0); load(3, 0, 0); load(4, 0, 0);
    clear_w();
    add_w(1, 0, 5); add_w(3, 2, 7); add_w(4, 2, 20);
    run(0, 0, 0, 0, 0, 0, 0, 0);

    // Early halt: write on halt cycle captured, next cycle ignored
    clear_w();
    add_w(6, 2, 20); add_w(7, 2, 99);
    run(6, 0, 0, 0, 0, 0, 0, 0);

    // Reset midway through CHECK
    clear_w();
    start = 1;
    k = cyc + 1;
    @(posedge clk); #1;
    start = 0;
    while (cyc < k + R + 4) begin
      @(posedge clk); #1;
    end
    chk("busy_in_check", 32'(busy), 1);
    reset = 1; #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    @(posedge clk); #1;
    golden_table();
    clear_w();
    add_w(3, 1, 10); add_w(4, 2, 20); add_w(20, 3, 30); add_w(47, 4, 10);
    run(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 7; i++) load(i, 10 * $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      r0 = $urandom_range(0, 1);
      if (r0 == 0) load(7, 10 * $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      clear_w();
      for (int j = 1; j < 60; j++)
        if ($urandom_range(0, 2) == 0) add_w(j, $urandom_range(0, 7), 10 * $urandom_range(0, 3));
      ha = ($urandom_range(0, 1) == 1) ? $urandom_range(1, R) : 0;
      last = (ha == 0) ? R : ha;
      run(ha, (last >= 2) && ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
          1'($urandom_range(0, 1)), (r0 == 1), 7, 10 * $urandom_range(0, 3),
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_commit_checker.md
# wb_commit_checker

Synthesizable writeback commit checker for the pipelined processor. It snoops the register-file write port (write enable, register index, data) and keeps a shadow register file. After a run window or a halt, it compares the shadow against a loaded table of expected values and reports pass/fail with mismatch statistics. It replaces hard-coded end-of-simulation register checks, and is generalised in data width, register count and run length so it can sit beside any core variant, in simulation or on FPGA.

## Interface
- DATA_W, 16, writeback data width
- REG_AW, 3, register index width; NREG = 2**REG_AW
- RUN_CYCLES, 48, maximum RUN-state length in cycles (≥1)
- ZERO_R0, 1, 1 = writes to index 0 are ignored in the shadow (r0 hard-wired zero)
- CNT_W, 16, width of cycle and write counters (saturating)
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  pulse; begins a run from IDLE or DONE, ignored otherwise
- halt  in  1  core-finished indication; ends RUN early
- wb_en  in  1  writeback enable
- wb_reg  in  REG_AW  writeback register index
- wb_data  in  DATA_W  writeback data
- exp_we  in  1  expected-table write strobe
- exp_idx  in  REG_AW  expected-table index
- exp_val  in  DATA_W  expected value
- exp_chk  in  1  compare-enable bit stored with exp_val
- rd_idx  in  REG_AW  shadow debug read index
- rd_data  out  DATA_W  shadow[rd_idx], combinational
- busy  out  1  high in RUN or CHECK
- done  out  1  high in DONE
- pass  out  1  done and mismatch_cnt == 0
- fail  out  1  done and mismatch_cnt != 0
- mismatch_cnt  out  REG_AW+1  number of failing checked registers
- first_bad  out  REG_AW  lowest failing index; 0 if none
- cycle_cnt  out  CNT_W  RUN cycles elapsed
- write_cnt  out  CNT_W  accepted writebacks during RUN

## Operation
- FSM states: IDLE, RUN, CHECK, DONE. Reset enters IDLE.
- IDLE/DONE + start → RUN. On that edge, clear the shadow, cycle_cnt, write_cnt, mismatch_cnt and first_bad, and set the check index to 0.
- RUN: each cycle increments cycle_cnt, saturating at all-ones.
  - When wb_en is high, write shadow[wb_reg] ← wb_data and increment write_cnt (saturating).
  - When ZERO_R0 = 1 and wb_reg = 0, the write is dropped and write_cnt still increments.
- RUN → CHECK when halt is high, or when cycle_cnt = RUN_CYCLES−1, whichever comes first.
  - A writeback in that final RUN cycle is captured.
  - halt outside RUN is ignored.
- CHECK: the index steps 0..NREG−1, one per cycle. For each index with exp_chk set and shadow ≠ exp_val:
  - increment mismatch_cnt;
  - if this is the first mismatch, load first_bad with the index.
  - Indices with exp_chk clear always pass.
- CHECK → DONE after index NREG−1 is evaluated. DONE holds all results until start or reset.
- wb_en outside RUN is ignored, with no shadow write and no count change.
- The expected table is written only in IDLE or DONE. exp_we in RUN or CHECK is dropped.
- exp_we together with start in the same cycle: the table write takes effect and the run starts.
- The expected table is not cleared by start. Reset clears every value and every exp_chk bit.
- Reset mid-run aborts immediately: state goes to IDLE, all outputs go to reset values, shadow is zeroed.

## Timing
- Reset values: busy, done, pass, fail = 0; mismatch_cnt, first_bad, cycle_cnt, write_cnt = 0; rd_data = 0.
- If start is sampled at edge k, busy is high from edge k.
- Latency without halt: done rises at edge k + RUN_CYCLES + NREG.
- If halt is sampled at RUN edge h, CHECK begins at h and done rises at h + NREG.
- rd_data follows shadow writes one edge after wb_en.
- pass and fail are mutually exclusive and valid only while done = 1.

## Test plan
- Golden run (defaults):
  - Load expected r1=10, r2=20, r3=30, r4=10 with chk set and all other chk bits clear.
  - start, then drive those four writebacks.
  - Result: done after 48+8 cycles; pass=1, mismatch_cnt=0, write_cnt=4.
- Mismatch:
  - Same table, but write r3=31 and r4=9.
  - Result: fail=1, mismatch_cnt=2, first_bad=3.
- r0 and last-writer:
  - Write r0=5, then write r2=7 followed by r2=20. Expected: r0=0 (chk set), r2=20.
  - Result: pass=1, rd_data at rd_idx=0 reads 0, write_cnt=3.
- Early halt:
  - Assert halt 6 cycles after start.
  - Result: done exactly 6+8 cycles after start, cycle_cnt=6. A writeback on the halt cycle is captured; one the cycle after is ignored.
- Boundary:
  - exp_we during RUN must not alter the table; verify that a later result still uses the old value.
  - Assert start during CHECK; it must be ignored.
  - Assert reset midway through CHECK; all outputs must read 0 and the next start must produce a correct result.
